// File: rtl/vga_sprite_compositor.sv
// VGA timing generator with NUM_SPRITES rectangular sprites composited over a
// background colour. Sprite state is shadowed during vertical blanking so a
// frame never tears, and player (sprite 0) overlap is reported once per frame.
module vga_sprite_compositor #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_PULSE     = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_PULSE     = 2,
  parameter int V_BACK      = 33,
  parameter int SYNC_POL    = 0,
  parameter int NUM_SPRITES = 5,
  parameter int CW          = 3
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NUM_SPRITES-1:0]       spr_en,
  input  logic [NUM_SPRITES*10-1:0]    spr_x,
  input  logic [NUM_SPRITES*10-1:0]    spr_y,
  input  logic [NUM_SPRITES*10-1:0]    spr_w,
  input  logic [NUM_SPRITES*10-1:0]    spr_h,
  input  logic [NUM_SPRITES*3*CW-1:0]  spr_rgb,
  input  logic [3*CW-1:0]              bg_rgb,
  output logic [9:0]                   h_count,
  output logic [9:0]                   v_count,
  output logic                         VGA_HS,
  output logic                         VGA_VS,
  output logic [CW-1:0]                VGA_R,
  output logic [CW-1:0]                VGA_G,
  output logic [CW-1:0]                VGA_B,
  output logic                         frame_start,
  output logic                         collision
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_PULSE + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_PULSE + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_PULSE);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_PULSE);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  localparam int PW = 3 * CW;

  // Raster counters
  logic [9:0] h_q, h_d, v_q, v_d;

  // Shadowed sprite descriptors used for drawing
  logic [NUM_SPRITES-1:0]      en_sh_q, en_sh_d;
  logic [NUM_SPRITES*10-1:0]   x_sh_q, x_sh_d, y_sh_q, y_sh_d;
  logic [NUM_SPRITES*10-1:0]   w_sh_q, w_sh_d, hgt_sh_q, hgt_sh_d;
  logic [NUM_SPRITES*PW-1:0]   rgb_sh_q, rgb_sh_d;

  // Output stage registers
  logic [PW-1:0] pix_q, pix_d;
  logic          hs_q, hs_d, vs_q, vs_d;
  logic          fs_q, fs_d;
  logic          acc_q, acc_d, coll_q, coll_d;

  logic                   latch;
  logic                   visible;
  logic                   overlap;
  logic [PW-1:0]          pix_sel;
  logic [NUM_SPRITES-1:0] hit;

  // Shadow update happens on the last pixel of the first blank line.
  assign latch = (h_q == H_LAST) && (v_q == V_VIS);

  // Per-sprite hit test in 11-bit space so x+w / y+h never wrap.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [10:0] x0, x1, y0, y1;
    assign x0 = {1'b0, x_sh_q[10*i +: 10]};
    assign x1 = x0 + {1'b0, w_sh_q[10*i +: 10]};
    assign y0 = {1'b0, y_sh_q[10*i +: 10]};
    assign y1 = y0 + {1'b0, hgt_sh_q[10*i +: 10]};
    assign hit[i] = en_sh_q[i] &&
                    ({1'b0, h_q} >= x0) && ({1'b0, h_q} < x1) &&
                    ({1'b0, v_q} >= y0) && ({1'b0, v_q} < y1);
  end

  // Next counter values: h wraps every line, v advances on each h wrap.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // Shadow registers follow the inputs only on the latch cycle.
  always_comb begin
    en_sh_d  = en_sh_q;
    x_sh_d   = x_sh_q;
    y_sh_d   = y_sh_q;
    w_sh_d   = w_sh_q;
    hgt_sh_d = hgt_sh_q;
    rgb_sh_d = rgb_sh_q;
    if (latch) begin
      en_sh_d  = spr_en;
      x_sh_d   = spr_x;
      y_sh_d   = spr_y;
      w_sh_d   = spr_w;
      hgt_sh_d = spr_h;
      rgb_sh_d = spr_rgb;
    end
  end

  // Priority pick (lowest index wins), blanking, sync and frame pulse.
  always_comb begin
    visible = (h_q < H_VIS) && (v_q < V_VIS);
    pix_sel = bg_rgb;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit[i]) pix_sel = rgb_sh_q[PW*i +: PW];
    end
    pix_d = visible ? pix_sel : '0;
    hs_d  = ((h_q >= HS_START) && (h_q < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
    vs_d  = ((v_q >= VS_START) && (v_q < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
    fs_d  = (h_q == '0) && (v_q == '0);
  end

  // Collision accumulator; the latch cycle publishes and clears it.
  always_comb begin
    overlap = visible && hit[0] && (|(hit >> 1));
    acc_d   = acc_q;
    coll_d  = coll_q;
    if (latch) begin
      coll_d = acc_q;
      acc_d  = 1'b0;
    end else if (overlap) begin
      acc_d  = 1'b1;
    end
  end

  // State registers; everything returns to an idle, blank, zero-counter state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      h_q      <= '0;
      v_q      <= '0;
      en_sh_q  <= '0;
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      w_sh_q   <= '0;
      hgt_sh_q <= '0;
      rgb_sh_q <= '0;
      pix_q    <= '0;
      hs_q     <= ~SYNC_ACT;
      vs_q     <= ~SYNC_ACT;
      fs_q     <= 1'b0;
      acc_q    <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      en_sh_q  <= en_sh_d;
      x_sh_q   <= x_sh_d;
      y_sh_q   <= y_sh_d;
      w_sh_q   <= w_sh_d;
      hgt_sh_q <= hgt_sh_d;
      rgb_sh_q <= rgb_sh_d;
      pix_q    <= pix_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
      acc_q    <= acc_d;
      coll_q   <= coll_d;
    end
  end

  assign h_count             = h_q;
  assign v_count             = v_q;
  assign {VGA_R, VGA_G, VGA_B} = pix_q;
  assign VGA_HS              = hs_q;
  assign VGA_VS              = vs_q;
  assign frame_start         = fs_q;
  assign collision           = coll_q;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Bench for vga_sprite_compositor on a reduced raster: a reference model
// pushes expected pixel/sync/pulse values each clock, a negedge monitor pops
// and compares them, and scenario tasks add targeted spot checks.
module tb_vga_sprite_compositor;

  localparam int HD = 40, HF = 4, HP = 6, HB = 6;
  localparam int VD = 30, VF = 2, VP = 2, VB = 3;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int FRAME = HT * VT;
  localparam int N = 5, CW = 3;

  logic              clk, rst_n;
  logic [N-1:0]      spr_en;
  logic [N*10-1:0]   spr_x, spr_y, spr_w, spr_h;
  logic [N*9-1:0]    spr_rgb;
  logic [8:0]        bg_rgb;

  logic [9:0]  h_count, v_count, h_count_p, v_count_p;
  logic        hs, vs, hs_p, vs_p, fs, fs_p, coll, coll_p;
  logic [2:0]  r, g, b, r_p, g_p, b_p;

  int tests_run = 0;
  int tests_failed = 0;

  vga_sprite_compositor #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .SYNC_POL(0), .NUM_SPRITES(N), .CW(CW)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .spr_w(spr_w), .spr_h(spr_h), .spr_rgb(spr_rgb), .bg_rgb(bg_rgb),
    .h_count(h_count), .v_count(v_count), .VGA_HS(hs), .VGA_VS(vs),
    .VGA_R(r), .VGA_G(g), .VGA_B(b), .frame_start(fs), .collision(coll)
  );

  vga_sprite_compositor #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .SYNC_POL(1), .NUM_SPRITES(N), .CW(CW)
  ) dut_p (
    .CLK(clk), .RST_N(rst_n), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
    .spr_w(spr_w), .spr_h(spr_h), .spr_rgb(spr_rgb), .bg_rgb(bg_rgb),
    .h_count(h_count_p), .v_count(v_count_p), .VGA_HS(hs_p), .VGA_VS(vs_p),
    .VGA_R(r_p), .VGA_G(g_p), .VGA_B(b_p), .frame_start(fs_p), .collision(coll_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_h, m_v;
  int         m_x[N], m_y[N], m_w[N], m_hh[N];
  logic [8:0] m_c[N];
  logic       m_en[N];
  logic       m_acc, m_coll, m_latch, m_vis, m_hs, m_vs, m_ov, m_other;
  logic [8:0] m_px;
  logic [12:0] exp_q[$];   // {px, hs_active, vs_active, frame_start, collision}

  function automatic logic model_hit(int i, int h, int v);
    return m_en[i] && (h >= m_x[i]) && (h < m_x[i] + m_w[i]) &&
           (v >= m_y[i]) && (v < m_y[i] + m_hh[i]);
  endfunction

  function automatic logic [8:0] model_pixel(int h, int v, logic [8:0] bg);
    logic [8:0] c;
    if (h >= HD || v >= VD) return 9'h000;
    c = bg;
    for (int i = N - 1; i >= 0; i--) if (model_hit(i, h, v)) c = m_c[i];
    return c;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_h = 0; m_v = 0; m_acc = 1'b0; m_coll = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_x[i] = 0; m_y[i] = 0; m_w[i] = 0; m_hh[i] = 0; m_c[i] = '0; m_en[i] = 1'b0;
      end
    end else begin
      m_vis   = (m_h < HD) && (m_v < VD);
      m_px    = model_pixel(m_h, m_v, bg_rgb);
      m_hs    = (m_h >= HD + HF) && (m_h < HD + HF + HP);
      m_vs    = (m_v >= VD + VF) && (m_v < VD + VF + VP);
      m_latch = (m_h == HT - 1) && (m_v == VD);
      m_other = 1'b0;
      for (int j = 1; j < N; j++) if (model_hit(j, m_h, m_v)) m_other = 1'b1;
      m_ov = m_vis && model_hit(0, m_h, m_v) && m_other;
      if (m_latch) begin
        m_coll = m_acc;
        m_acc  = 1'b0;
      end else if (m_ov) begin
        m_acc = 1'b1;
      end
      exp_q.push_back({m_px, m_hs, m_vs, (m_h == 0 && m_v == 0), m_coll});
      if (m_latch) begin
        for (int i = 0; i < N; i++) begin
          m_en[i] = spr_en[i];
          m_x[i]  = int'(spr_x[i*10 +: 10]);
          m_y[i]  = int'(spr_y[i*10 +: 10]);
          m_w[i]  = int'(spr_w[i*10 +: 10]);
          m_hh[i] = int'(spr_h[i*10 +: 10]);
          m_c[i]  = spr_rgb[i*9 +: 9];
        end
      end
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [12:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      tests_run++;
      if ({h_count, v_count, r, g, b, hs, vs, fs, coll} !== {20'd0, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0} ||
          {h_count_p, v_count_p, r_p, g_p, b_p, hs_p, vs_p, fs_p, coll_p} !== 33'd0) begin
        tests_failed++;
        $display("FAIL reset_state t=%0t: pol0 h=%0d v=%0d rgb=%h hs=%b vs=%b fs=%b coll=%b pol1 hs=%b vs=%b rgb=%h, required zeros with pol0 syncs high, pol1 syncs low",
                 $time, h_count, v_count, {r, g, b}, hs, vs, fs, coll, hs_p, vs_p, {r_p, g_p, b_p});
      end
    end else begin
      tests_run++;
      if (h_count !== 10'(m_h) || v_count !== 10'(m_v) ||
          h_count_p !== 10'(m_h) || v_count_p !== 10'(m_v)) begin
        tests_failed++;
        $display("FAIL counters t=%0t: got (%0d,%0d)/(%0d,%0d) required (%0d,%0d)",
                 $time, h_count, v_count, h_count_p, v_count_p, m_h, m_v);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if ({r, g, b, hs, vs, fs, coll} !== {e[12:4], ~e[3], ~e[2], e[1], e[0]} ||
            {r_p, g_p, b_p, hs_p, vs_p, fs_p, coll_p} !== e) begin
          tests_failed++;
          $display("FAIL stream t=%0t at (%0d,%0d): pol0 rgb=%h hs=%b vs=%b fs=%b coll=%b pol1 rgb=%h hs=%b vs=%b, required rgb=%h hs_active=%b vs_active=%b fs=%b coll=%b",
                   $time, m_h, m_v, {r, g, b}, hs, vs, fs, coll, {r_p, g_p, b_p}, hs_p, vs_p,
                   e[12:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_spr(input int i, input int x, input int y, input int w, input int h,
                         input logic [8:0] c, input logic en);
    spr_x[i*10 +: 10] = 10'(x);
    spr_y[i*10 +: 10] = 10'(y);
    spr_w[i*10 +: 10] = 10'(w);
    spr_h[i*10 +: 10] = 10'(h);
    spr_rgb[i*9 +: 9] = c;
    spr_en[i]         = en;
  endtask

  task automatic wait_hv(input int h, input int v);
    for (int n = 0; n < 3 * FRAME; n++) begin
      @(posedge clk); #1;
      if (h_count == 10'(h) && v_count == 10'(v)) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL wait_hv: counters never read (%0d,%0d), timed out", h, v);
  endtask

  // Returns the RGB produced for raster position (h,v), one cycle later.
  task automatic sample_px(input int h, input int v, output logic [8:0] px);
    wait_hv(h, v);
    @(posedge clk); #1;
    px = {r, g, b};
  endtask

  task automatic wait_latch();
    wait_hv(HT - 1, VD);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (h_count !== 10'd0 || v_count !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: got (%0d,%0d) required (0,0)", h_count, v_count);
    end
    tests_run++;
    if ({r, g, b} !== 9'h000 || fs !== 1'b0 || coll !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rgb=%h fs=%b coll=%b required 000/0/0", {r, g, b}, fs, coll);
    end
    tests_run++;
    if ({hs, vs, hs_p, vs_p} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_sync: got %b required 1100", {hs, vs, hs_p, vs_p});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timing();
    int n_fs, n_hs, n_vs;
    n_fs = 0; n_hs = 0; n_vs = 0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      @(posedge clk); #1;
      if (fs) n_fs++;
      if (n < FRAME && !hs) n_hs++;
      if (n < FRAME && !vs) n_vs++;
    end
    tests_run++;
    if (n_fs != 2) begin
      tests_failed++;
      $display("FAIL frame_start_count: got %0d required 2", n_fs);
    end
    tests_run++;
    if (n_hs != HP * VT) begin
      tests_failed++;
      $display("FAIL hs_low_cycles: got %0d required %0d", n_hs, HP * VT);
    end
    tests_run++;
    if (n_vs != VP * HT) begin
      tests_failed++;
      $display("FAIL vs_low_cycles: got %0d required %0d", n_vs, VP * HT);
    end
  endtask

  task automatic test_priority();
    logic [8:0] px;
    int         hs_tab[7] = '{5, 10, 18, 15, 20, 21, 22};
    int         vs_tab[7] = '{5, 10, 10, 15, 20, 21, 22};
    logic [8:0] ex_tab[7] = '{9'h049, 9'h1C0, 9'h049, 9'h1C0, 9'h007, 9'h007, 9'h049};
    set_spr(0, 10, 10, 8, 8, 9'h1C0, 1'b1);
    set_spr(1, 14, 14, 8, 8, 9'h007, 1'b1);
    wait_latch();
    for (int k = 0; k < 7; k++) begin
      sample_px(hs_tab[k], vs_tab[k], px);
      tests_run++;
      if (px !== ex_tab[k]) begin
        tests_failed++;
        $display("FAIL priority_px(%0d,%0d): got %h required %h", hs_tab[k], vs_tab[k], px, ex_tab[k]);
      end
    end
  endtask

  task automatic test_collision();
    wait_latch();
    tests_run++;
    if (coll !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_set: got %b required 1", coll);
    end
    set_spr(1, 30, 25, 4, 4, 9'h007, 1'b1);
    wait_latch();
    tests_run++;
    if (coll !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_hold: got %b required 1", coll);
    end
    wait_latch();
    tests_run++;
    if (coll !== 1'b0) begin
      tests_failed++;
      $display("FAIL collision_clear: got %b required 0", coll);
    end
  endtask

  task automatic test_shadow();
    logic [8:0] px;
    wait_hv(0, 15);
    spr_x[9:0] = 10'd20;
    sample_px(11, 16, px);
    tests_run++;
    if (px !== 9'h1C0) begin
      tests_failed++;
      $display("FAIL shadow_old_pos: got %h required 1c0", px);
    end
    sample_px(21, 16, px);
    tests_run++;
    if (px !== 9'h049) begin
      tests_failed++;
      $display("FAIL shadow_new_pos_early: got %h required 049", px);
    end
    wait_latch();
    sample_px(11, 16, px);
    tests_run++;
    if (px !== 9'h049) begin
      tests_failed++;
      $display("FAIL shadow_old_pos_next: got %h required 049", px);
    end
    sample_px(21, 16, px);
    tests_run++;
    if (px !== 9'h1C0) begin
      tests_failed++;
      $display("FAIL shadow_new_pos_next: got %h required 1c0", px);
    end
  endtask

  task automatic test_edge();
    logic [8:0] px;
    int         hs_tab[4] = '{0, 34, 2, 5};
    int         vs_tab[4] = '{0, 0, 3, 3};
    logic [8:0] ex_tab[4] = '{9'h0AA, 9'h155, 9'h0AA, 9'h0AA};
    bg_rgb = 9'h0AA;
    set_spr(0, 10, 10, 8, 8, 9'h1C0, 1'b0);
    set_spr(1, 14, 14, 8, 8, 9'h007, 1'b0);
    set_spr(2, 1020, 0, 10, 30, 9'h038, 1'b1);
    set_spr(3, 0, 0, 0, 30, 9'h1FF, 1'b1);
    set_spr(4, 34, 0, 3, 1, 9'h155, 1'b1);
    wait_latch();
    for (int k = 0; k < 4; k++) begin
      sample_px(hs_tab[k], vs_tab[k], px);
      tests_run++;
      if (px !== ex_tab[k]) begin
        tests_failed++;
        $display("FAIL edge_px(%0d,%0d): got %h required %h", hs_tab[k], vs_tab[k], px, ex_tab[k]);
      end
    end
  endtask

  task automatic test_midreset();
    wait_hv(20, 5);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({h_count, v_count} !== 20'd0 || {r, g, b} !== 9'h000 || fs !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_immediate: h=%0d v=%0d rgb=%h fs=%b required 0,0,000,0",
               h_count, v_count, {r, g, b}, fs);
    end
    tests_run++;
    if ({hs, vs, hs_p, vs_p} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL midreset_sync: got %b required 1100", {hs, vs, hs_p, vs_p});
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (h_count !== 10'd1 || v_count !== 10'd0 || hs_p !== 1'b0 || vs_p !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_restart: h=%0d v=%0d hs_p=%b vs_p=%b required 1,0,0,0",
               h_count, v_count, hs_p, vs_p);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    spr_en  = '0;
    spr_x   = '0;
    spr_y   = '0;
    spr_w   = '0;
    spr_h   = '0;
    spr_rgb = '0;
    bg_rgb  = 9'h049;
    test_reset();
    test_timing();
    test_priority();
    test_collision();
    test_shadow();
    test_edge();
    test_midreset();
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_sprite_compositor.md
Name: vga_sprite_compositor

Overview:
- Parametrised successor to the team's fixed-size VGA timing and pixel block.
- Generates programmable VGA timing and composites NUM_SPRITES rectangular sprites over a background colour supplied by the map logic.
- Latches sprite positions only during vertical blanking, so a frame never tears.
- Reports sprite-0 (player) overlap with any other sprite once per frame.
- Sits between the game-logic/map blocks and the VGA pins.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_PULSE, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_PULSE, 2, vertical sync width
- V_BACK, 33, vertical back porch
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- NUM_SPRITES, 5, sprite count (1..8); sprite 0 is the player
- CW, 3, bits per colour channel

Ports:
- CLK  in  1  pixel clock
- RST_N  in  1  asynchronous active-low reset
- spr_en  in  NUM_SPRITES  per-sprite enable
- spr_x  in  NUM_SPRITES*10  left edge, sprite i in bits [10i+9:10i]
- spr_y  in  NUM_SPRITES*10  top edge
- spr_w  in  NUM_SPRITES*10  width in pixels
- spr_h  in  NUM_SPRITES*10  height in lines
- spr_rgb  in  NUM_SPRITES*3*CW  colour {R,G,B}
- bg_rgb  in  3*CW  background colour for the current h_count/v_count
- h_count  out  10  current horizontal counter
- v_count  out  10  current vertical counter
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- VGA_R  out  CW  red
- VGA_G  out  CW  green
- VGA_B  out  CW  blue
- frame_start  out  1  one-cycle pulse at h=0, v=0
- collision  out  1  player overlapped another sprite in the previous frame

Behaviour:
- Reset (async assert, sync release):
  - h_count = 0, v_count = 0.
  - RGB outputs = 0.
  - VGA_HS and VGA_VS inactive (= ~SYNC_POL).
  - frame_start = 0, collision = 0.
  - Shadow sprite registers and spr_en shadow cleared.
- Counters:
  - H_TOTAL = H_DISPLAY + H_FRONT + H_PULSE + H_BACK; V_TOTAL is defined the same way.
  - h_count increments every cycle and wraps H_TOTAL-1 -> 0.
  - v_count increments on each h wrap and wraps V_TOTAL-1 -> 0.
- Shadow latch:
  - While h_count == H_TOTAL-1 and v_count == V_DISPLAY (first blank line), all spr_* inputs are copied into shadow registers.
  - Compositing uses shadow values only. Input changes at any other time have no effect until the next latch.
- Compositing pipeline, combinational from h_count/v_count/shadow/bg_rgb, registered once:
  - Pixel visible = h_count < H_DISPLAY and v_count < V_DISPLAY.
  - Hit i = shadow_en[i] and x <= h < x+w and y <= v < y+h.
  - Compare in 11-bit arithmetic so x+w > 1023 does not wrap.
  - w = 0 or h = 0 means never hit.
  - Lowest index wins (sprite 0 has highest priority); no hit gives bg_rgb.
  - Not visible gives RGB = 0.
  - Latency: RGB, VGA_HS and VGA_VS reflect the counter value of the previous cycle. Sync is registered in the same stage so it stays aligned with RGB.
  - h_count/v_count outputs are the current values, which gives the map block one cycle to supply bg_rgb.
- Sync:
  - HS active when H_DISPLAY+H_FRONT <= h < H_DISPLAY+H_FRONT+H_PULSE.
  - VS uses the equivalent vertical window.
  - Active level = SYNC_POL.
- frame_start: registered, high exactly one cycle, in the cycle after the counters read (0,0).
- Collision:
  - A sticky accumulator sets on any visible pixel where hit 0 and any hit j (j > 0) are both true.
  - On the shadow-latch cycle, collision <= accumulator and the accumulator clears.
  - If a new overlap occurs in that same cycle, clearing wins.
  - collision holds its value for a full frame.
- Reset mid-frame: counters restart at 0,0 and no stale frame_start pulse is emitted.

Test Plan:
- Reset, then run 1 frame at defaults -> HS low for 96 cycles starting 1 cycle after h=656; VS low on lines 490–491; H_TOTAL = 800, V_TOTAL = 525; one frame_start per 420000 cycles.
- Sprite 0 at (100,100) 16x16 with rgb 0x1C0, sprite 1 at (108,108) 16x16 with rgb 0x007, bg 0x049 -> pixel (110,110) outputs 0x1C0, (120,120) outputs 0x007, (50,50) outputs 0x049; every output 1 cycle after the counter value.
- Same overlap held for 1 frame -> collision = 1 after the v = 480 latch; move sprite 1 to (300,300) -> collision = 0 one frame later.
- Change spr_x[0] from 100 to 200 at v = 240 -> rest of the current frame still drawn at x = 100; next frame drawn at 200.
- Sprite at x = 1020, w = 10; sprite with w = 0 -> no wrap hits at h < 10; the zero-width sprite is never drawn.
- SYNC_POL = 1 build with reset asserted mid-line -> outputs reset immediately; after release HS/VS idle low and counters start at 0.
